ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the MIPS-lite core. It holds the architectural PC and fetches one word per instruction from instruction memory over a req/ack handshake. It presents the fetched instruction to decode/`ctrl`, and computes the next PC from the `ctrl` next-PC select, the ALU zero flag and the `jr` register operand. It sits directly upstream of `ctrl` and consumes its `s_npc` output.

## Interface
- `RESET_PC`, `32'h0000_3000`, PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `s_npc` in 2: next-PC select from `ctrl`.
- `zero` in 1: ALU equality result, used for `beq`.
- `ra_data` in 32: GPR[rs], the target for `jr`.
- `retire` in 1: datapath has finished executing the held instruction; advance the PC.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, always equal to `pc`.
- `imem_rdata` in 32: fetched word, valid when `imem_ack`=1.
- `imem_ack` in 1: fetch complete.
- `instr` out 32: held instruction register (IR).
- `instr_valid` out 1: IR holds the instruction at `pc`.
- `pc` out 32: current PC.
- `pc_plus4` out 32: `pc`+4, the `jal` link value.
- `misalign` out 1: sticky misaligned-target flag; tied 0 when the feature is off.

## Operation
- **FSM states:** FETCH, EXEC, and TRAP (TRAP only with the macro).
- **FETCH:** `imem_req`=1, `instr_valid`=0.
  - On `imem_ack`: IR<=`imem_rdata`, go to EXEC.
  - `retire` is ignored in this state.
- **EXEC:** `imem_req`=0, `instr_valid`=1.
  - On `retire`: `pc`<=npc, go to FETCH.
  - `imem_ack` is ignored in this state.
- **npc selection by `s_npc`:**
  - `00` (beq): `zero` ? `pc`+4+(sext(IR[15:0])<<2) : `pc`+4.
  - `01` (jr): `ra_data`.
  - `10` (j/jal): {`pc_plus4`[31:28], IR[25:0], 2'b00}.
  - `11`: `pc`+4.
- **Arithmetic:** all additions are 32-bit modulo 2^32. `pc`=`32'hFFFF_FFFC` sequential wraps to 0. A branch offset carrying past bit 31 wraps silently.
- **Retire timing:** `s_npc`, `zero` and `ra_data` are sampled only in the `retire` cycle.
- **Reset values:** `pc`=`RESET_PC`, IR=0, state=FETCH. Outputs after reset: `imem_req`=1, `instr_valid`=0, `instr`=0, `misalign`=0, `pc_plus4`=`RESET_PC`+4.
- **Reset priority:** `rst_n` low wins over every event, including mid-fetch with `imem_ack` high. The pending fetch is abandoned and any late ack is ignored. The next fetch is at `RESET_PC`.

## Timing
- `imem_req`, `imem_addr` and `instr_valid` are decoded from registered state/PC only, never from inputs.
- Zero-wait memory (ack in the same cycle as req): IR and `instr_valid` update the next cycle.
- Minimum of 2 cycles per instruction (FETCH, EXEC), with `retire` in the first EXEC cycle.
- `pc` changes only on the clock edge that leaves EXEC. The new `imem_addr` is visible in the following FETCH cycle.
- Wait states: `imem_req` stays high and `imem_addr` stays stable until ack. There is no timeout.
- `instr` and `pc` are stable for the whole EXEC period, so `ctrl` outputs are stable.

## Configuration
- **`IFU_MISALIGN_TRAP_EN` defined:** in the `retire` cycle, if npc[1:0]!=0, `pc` is not updated and the FSM goes to TRAP.
  - In TRAP: `imem_req`=0, `instr_valid`=0, `misalign`=1.
  - TRAP is held until reset.
- **`IFU_MISALIGN_TRAP_EN` undefined:**
  - npc[1:0] is forced to 00.
  - TRAP does not exist.
  - `misalign` is constant 0.

## Structure
- The shared header holds the npc select codes `NPC_BEQ`=2'b00, `NPC_JR`=2'b01, `NPC_J`=2'b10 and `NPC_PC4`=2'b11, used by both `ctrl` and `ifu`.
- The FSM state encodings are local to `ifu`.
- Sub-module `npc`: combinational next-PC computation.
  - Inputs: `pc`, IR[25:0], `s_npc`, `zero`, `ra_data`.
  - Outputs: npc, `pc_plus4`.

## Test plan
- **Reset, zero-wait memory:** release reset with ack tied 1 -> `imem_addr`=0x3000 in cycle 0, `instr_valid`=1 in cycle 1; `retire` with `s_npc`=11 -> next `imem_addr`=0x3004.
- **beq taken/not taken:** IR=0x1000FFFF at `pc`=0x3010, `s_npc`=00.
  - `zero`=1 -> `pc`=0x3010.
  - `zero`=0 -> `pc`=0x3014.
- **j and jr:**
  - IR=0x08000C10 at `pc`=0x3000, `s_npc`=10 -> `pc`=0x3040.
  - `s_npc`=01, `ra_data`=0x3100 -> `pc`=0x3100.
- **Wait states, then reset mid-fetch:** ack delayed 3 cycles -> `imem_addr` stable and `instr_valid`=0 throughout. Then assert `rst_n`=0 in the same cycle as ack -> IR=0 and next `imem_addr`=0x3000.
- **Wrap:** `pc`=0xFFFFFFFC with `s_npc`=11 -> `pc`=0.
- **Misaligned jr:** `ra_data`=0x3102.
  - With `IFU_MISALIGN_TRAP_EN`: `misalign`=1 and `imem_req`=0 persist, `pc` unchanged.
  - Without the macro: `pc`=0x3100.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared MIPS-lite fetch definitions: next-PC select codes used by ctrl and ifu,
// plus the branch-offset helper.
package ifu_pkg;

   localparam logic [1:0] NPC_BEQ = 2'b00;
   localparam logic [1:0] NPC_JR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_PC4 = 2'b11;

   // sext(imm16) << 2, as a 32-bit byte offset
   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC computation for the fetch unit (beq / jr / j / pc+4).
module ifu_npc
   import ifu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [25:0] ir_idx,
   input  logic [1:0]  s_npc,
   input  logic        zero,
   input  logic [31:0] ra_data,
   output logic [31:0] npc,
   output logic [31:0] pc_plus4
);

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      npc = pc_plus4;
      case (s_npc)
         NPC_BEQ: if (zero) npc = pc_plus4 + br_offset(ir_idx[15:0]);
         NPC_JR:  npc = ra_data;
         NPC_J:   npc = {pc_plus4[31:28], ir_idx, 2'b00};
         default: npc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: holds PC and IR, fetches over req/ack, advances on retire.
// Optional IFU_MISALIGN_TRAP_EN: misaligned next-PC traps instead of being truncated.
module ifu
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  s_npc,
   input  logic        zero,
   input  logic [31:0] ra_data,
   input  logic        retire,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        misalign
);

`ifdef IFU_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, TRAP = 2'd2} state_t;
`else
   typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;
`endif

   state_t      state, state_n;
   logic [31:0] pc_q, ir_q;
   logic [31:0] npc_raw, npc;
   logic        ld_ir, ld_pc;

   ifu_npc u_npc (
      .pc       (pc_q),
      .ir_idx   (ir_q[25:0]),
      .s_npc    (s_npc),
      .zero     (zero),
      .ra_data  (ra_data),
      .npc      (npc_raw),
      .pc_plus4 (pc_plus4)
   );

`ifdef IFU_MISALIGN_TRAP_EN
   assign npc = npc_raw;
`else
   // without the trap, word alignment is enforced by dropping the low bits
   assign npc = npc_raw & ~32'h3;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= FETCH;
         pc_q  <= RESET_PC;
         ir_q  <= '0;
      end else begin
         state <= state_n;
         if (ld_ir) ir_q <= imem_rdata;
         if (ld_pc) pc_q <= npc;
      end
   end

   // outputs depend on registered state only; inputs only steer loads/transitions
   always_comb begin
      state_n     = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      misalign    = 1'b0;
      ld_ir       = 1'b0;
      ld_pc       = 1'b0;
      case (state)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ld_ir   = 1'b1;
               state_n = EXEC;
            end
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (retire) begin
`ifdef IFU_MISALIGN_TRAP_EN
               if (npc[1:0] != 2'b00) begin
                  state_n = TRAP;
               end else begin
                  ld_pc   = 1'b1;
                  state_n = FETCH;
               end
`else
               ld_pc   = 1'b1;
               state_n = FETCH;
`endif
            end
         end
`ifdef IFU_MISALIGN_TRAP_EN
         TRAP: misalign = 1'b1;
`endif
         default: state_n = FETCH;
      endcase
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign instr     = ir_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: vector table of single-instruction fetch/retire steps
// plus hand sequences for reset, wait states, reset mid-fetch and misaligned jr.
module tb_ifu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  s_npc;
   logic        zero;
   logic [31:0] ra_data;
   logic        retire;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misalign;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ifu dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_npc       (s_npc),
      .zero        (zero),
      .ra_data     (ra_data),
      .retire      (retire),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ack    (imem_ack),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .misalign    (misalign)
   );

   typedef struct {
      logic [31:0] ir;
      logic [1:0]  sel;
      logic        z;
      logic [31:0] ra;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one instruction with zero-wait memory, starting and ending in FETCH
   task automatic run_vec(input int i);
      imem_ack   = 1'b1;
      imem_rdata = vecs[i].ir;
      step();
      imem_ack   = 1'b0;
      chk($sformatf("v%0d instr", i), instr, vecs[i].ir);
      chk($sformatf("v%0d valid", i), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("v%0d req_exec", i), {31'd0, imem_req}, 32'd0);
      retire  = 1'b1;
      s_npc   = vecs[i].sel;
      zero    = vecs[i].z;
      ra_data = vecs[i].ra;
      step();
      retire = 1'b0;
      chk($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d addr", i), imem_addr, vecs[i].exp_pc);
      chk($sformatf("v%0d pc4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d req_fetch", i), {31'd0, imem_req}, 32'd1);
   endtask

   initial begin
      //            ir            sel    z     ra             exp_pc
      vecs[0]  = '{32'h0800_0C10, 2'b10, 1'b0, 32'h0,         32'h0000_3040}; // j
      vecs[1]  = '{32'h0000_0000, 2'b11, 1'b1, 32'h0,         32'h0000_3044}; // pc+4
      vecs[2]  = '{32'h0040_0008, 2'b01, 1'b0, 32'h0000_3010, 32'h0000_3010}; // jr
      vecs[3]  = '{32'h1000_FFFF, 2'b00, 1'b1, 32'h0,         32'h0000_3010}; // beq taken, -4
      vecs[4]  = '{32'h1000_FFFF, 2'b00, 1'b0, 32'h0,         32'h0000_3014}; // beq not taken
      vecs[5]  = '{32'h0040_0008, 2'b01, 1'b0, 32'h0000_3100, 32'h0000_3100};
      vecs[6]  = '{32'h1000_0010, 2'b00, 1'b1, 32'h0,         32'h0000_3144}; // beq +0x40
      vecs[7]  = '{32'h1000_0010, 2'b11, 1'b1, 32'h0,         32'h0000_3148}; // zero ignored
      vecs[8]  = '{32'h0040_0008, 2'b01, 1'b0, 32'hA000_0000, 32'hA000_0000};
      vecs[9]  = '{32'h0BFF_FFFF, 2'b10, 1'b0, 32'h0,         32'hAFFF_FFFC}; // j keeps pc4[31:28]
      vecs[10] = '{32'h0040_0008, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
      vecs[11] = '{32'h0000_0000, 2'b11, 1'b0, 32'h0,         32'h0000_0000}; // sequential wrap
      vecs[12] = '{32'h0040_0008, 2'b01, 1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
      vecs[13] = '{32'h1000_0002, 2'b00, 1'b1, 32'h0,         32'h0000_0004}; // branch wrap

      rst_n = 1'b0; s_npc = 2'b11; zero = 1'b0; ra_data = '0; retire = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'h2400_0001;

      // reset with ack tied high
      step(); step();
      rst_n = 1'b1;
      chk("rst addr", imem_addr, 32'h0000_3000);
      chk("rst req", {31'd0, imem_req}, 32'd1);
      chk("rst valid", {31'd0, instr_valid}, 32'd0);
      chk("rst instr", instr, 32'd0);
      chk("rst pc4", pc_plus4, 32'h0000_3004);
      chk("rst misalign", {31'd0, misalign}, 32'd0);
      step();
      chk("zw valid", {31'd0, instr_valid}, 32'd1);
      chk("zw instr", instr, 32'h2400_0001);
      retire = 1'b1; s_npc = 2'b11;
      step();
      retire = 1'b0; imem_ack = 1'b0;
      chk("zw next addr", imem_addr, 32'h0000_3004);

      // start at 0x3004, end at 0x0004, then jr back to 0x3000
      for (int i = 0; i < 14; i++) run_vec(i);
      imem_ack = 1'b1; imem_rdata = 32'h0040_0008;
      step();
      imem_ack = 1'b0; retire = 1'b1; s_npc = 2'b01; ra_data = 32'h0000_3000;
      step();
      retire = 1'b0;
      chk("back pc", pc, 32'h0000_3000);

      // EXEC holds: late ack and non-retire-cycle selects are ignored
      imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
      step();
      imem_rdata = 32'h5555_0000; s_npc = 2'b01; ra_data = 32'hDEAD_0000;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("hold instr", instr, 32'hAAAA_0001);
         chk("hold valid", {31'd0, instr_valid}, 32'd1);
         chk("hold pc", pc, 32'h0000_3000);
      end
      imem_ack = 1'b0; retire = 1'b1; s_npc = 2'b11;
      step();

      // wait states: retire ignored while fetching, address stable
      for (int k = 0; k < 3; k++) begin
         step();
         chk("wait addr", imem_addr, 32'h0000_3004);
         chk("wait req", {31'd0, imem_req}, 32'd1);
         chk("wait valid", {31'd0, instr_valid}, 32'd0);
      end
      retire = 1'b0;

      // reset coincident with ack
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678; rst_n = 1'b0;
      step();
      rst_n = 1'b1; imem_ack = 1'b0;
      chk("rstack instr", instr, 32'd0);
      chk("rstack addr", imem_addr, 32'h0000_3000);
      chk("rstack valid", {31'd0, instr_valid}, 32'd0);
      step();
      chk("rstack req", {31'd0, imem_req}, 32'd1);
      chk("rstack valid2", {31'd0, instr_valid}, 32'd0);

      // misaligned jr
      imem_ack = 1'b1; imem_rdata = 32'h0040_0008;
      step();
      imem_ack = 1'b0; retire = 1'b1; s_npc = 2'b01; ra_data = 32'h0000_3102;
      step();
      retire = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      imem_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("trap misalign", {31'd0, misalign}, 32'd1);
         chk("trap req", {31'd0, imem_req}, 32'd0);
         chk("trap valid", {31'd0, instr_valid}, 32'd0);
         chk("trap pc", pc, 32'h0000_3000);
         retire = 1'b1;
         step();
      end
      retire = 1'b0; imem_ack = 1'b0;
`else
      chk("mis pc", pc, 32'h0000_3100);
      chk("mis misalign", {31'd0, misalign}, 32'd0);
      chk("mis req", {31'd0, imem_req}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
